// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the byte-serial RAM port between instruction fetch (icache miss path) and the
//   load/store unit. Arbitrates between the two requesters, then sequences a 1..4 byte
//   transfer one byte per cycle. Read bytes are assembled little-endian and returned with a
//   one-cycle done pulse. Stores towards the IO window back off while the IO write buffer is
//   full, and a branch flush abandons an in-flight fetch.
//
// Ports
//   clk_in, rst_n_in      clock, synchronous active-low reset
//   rdy_in                global enable; low freezes every register
//   if_*                  fetch request (addr, bytes-1), grant pulse, done pulse, read word
//   ls_*                  load/store request (wr, addr, bytes-1, store data), grant, done, load word
//   mem_din/mem_dout      RAM read byte (valid one cycle after address) / write byte
//   mem_a_out, mem_wr_out RAM byte address and write strobe
//   io_buffer_full_in     IO write buffer full; stalls store bytes at or above the IO base
//   clear_branch_in       misprediction flush; kills fetch acceptance and in-flight fetches
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    // Instruction fetch port
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    input  logic [1:0]            if_offset_in,
    output logic                  if_grant_out,
    output logic                  if_done_out,
    output logic [DATA_WIDTH-1:0] if_data_out,
    // Load/store port
    input  logic                  ls_req_in,
    input  logic                  ls_wr_in,
    input  logic [ADDR_WIDTH-1:0] ls_addr_in,
    input  logic [1:0]            ls_offset_in,
    input  logic [DATA_WIDTH-1:0] ls_data_in,
    output logic                  ls_grant_out,
    output logic                  ls_done_out,
    output logic [DATA_WIDTH-1:0] ls_data_out,
    // RAM port
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a_out,
    output logic                  mem_wr_out,
    // Side-band
    input  logic                  io_buffer_full_in,
    input  logic                  clear_branch_in
);

    // Start of the memory-mapped IO window; store bytes here are subject to backpressure.
    localparam logic [ADDR_WIDTH-1:0] IoBase = ADDR_WIDTH'(32'h0003_0000);

    localparam logic ServedIf = 1'b0;
    localparam logic ServedLs = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIfRead,
        StLsRead,
        StLsWrite
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            n_q;     // transfer length in bytes (1..4)
    logic [2:0]            cnt_q;   // bytes whose address has been issued
    logic [DATA_WIDTH-1:0] word_q;  // store data, or read bytes assembled so far
    logic                  last_served_q;

    logic                  if_grant_q;
    logic                  if_done_q;
    logic [DATA_WIDTH-1:0] if_data_q;
    logic                  ls_grant_q;
    logic                  ls_done_q;
    logic [DATA_WIDTH-1:0] ls_data_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic                  mem_wr_q;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [2:0]            cap_cnt;
    logic [1:0]            cap_idx;
    logic [1:0]            wr_idx;
    logic                  io_stall;
    logic                  if_cand;
    logic                  ls_cand;
    logic                  pick_if;
    logic                  pick_ls;
    logic [DATA_WIDTH-1:0] rd_word;

    assign next_addr = addr_q + ADDR_WIDTH'(cnt_q);
    assign wr_idx    = cnt_q[1:0];
    // The byte arriving on mem_din belongs to the address issued one edge earlier.
    assign cap_cnt   = cnt_q - 3'd1;
    assign cap_idx   = cap_cnt[1:0];
    assign io_stall  = io_buffer_full_in && (next_addr >= IoBase);

    assign if_cand = if_req_in && !clear_branch_in;
    assign ls_cand = ls_req_in &&
                     !(ls_wr_in && io_buffer_full_in && (ls_addr_in >= IoBase));
    // On contention the port that was not served last wins.
    assign pick_ls = ls_cand && (!if_cand || (last_served_q == ServedIf));
    assign pick_if = if_cand && !pick_ls;

    always_comb begin
        rd_word = word_q;
        rd_word[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            n_q           <= '0;
            cnt_q         <= '0;
            word_q        <= '0;
            last_served_q <= ServedIf;
            if_grant_q    <= 1'b0;
            if_done_q     <= 1'b0;
            if_data_q     <= '0;
            ls_grant_q    <= 1'b0;
            ls_done_q     <= 1'b0;
            ls_data_q     <= '0;
            mem_a_q       <= '0;
            mem_dout_q    <= '0;
            mem_wr_q      <= 1'b0;
        end else if (rdy_in) begin
            if_grant_q <= 1'b0;
            if_done_q  <= 1'b0;
            ls_grant_q <= 1'b0;
            ls_done_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    mem_wr_q <= 1'b0;
                    if (pick_ls) begin
                        ls_grant_q    <= 1'b1;
                        last_served_q <= ServedLs;
                        addr_q        <= ls_addr_in;
                        n_q           <= {1'b0, ls_offset_in} + 3'd1;
                        cnt_q         <= 3'd1;
                        mem_a_q       <= ls_addr_in;
                        if (ls_wr_in) begin
                            state_q    <= StLsWrite;
                            word_q     <= ls_data_in;
                            mem_dout_q <= ls_data_in[7:0];
                            mem_wr_q   <= 1'b1;
                        end else begin
                            state_q <= StLsRead;
                            word_q  <= '0;
                        end
                    end else if (pick_if) begin
                        if_grant_q    <= 1'b1;
                        last_served_q <= ServedIf;
                        addr_q        <= if_addr_in;
                        n_q           <= {1'b0, if_offset_in} + 3'd1;
                        cnt_q         <= 3'd1;
                        mem_a_q       <= if_addr_in;
                        word_q        <= '0;
                        state_q       <= StIfRead;
                    end
                end

                StIfRead: begin
                    if (clear_branch_in) begin
                        state_q <= StIdle;
                    end else if (cnt_q == n_q) begin
                        if_data_q <= rd_word;
                        if_done_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        word_q  <= rd_word;
                        mem_a_q <= next_addr;
                        cnt_q   <= cnt_q + 3'd1;
                    end
                end

                StLsRead: begin
                    if (cnt_q == n_q) begin
                        ls_data_q <= rd_word;
                        ls_done_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        word_q  <= rd_word;
                        mem_a_q <= next_addr;
                        cnt_q   <= cnt_q + 3'd1;
                    end
                end

                StLsWrite: begin
                    if (cnt_q == n_q) begin
                        mem_wr_q  <= 1'b0;
                        ls_done_q <= 1'b1;
                        state_q   <= StIdle;
                    end else if (io_stall) begin
                        // Hold the counter; the same byte is retried next edge.
                        mem_wr_q <= 1'b0;
                    end else begin
                        mem_a_q    <= next_addr;
                        mem_dout_q <= word_q[{wr_idx, 3'b000} +: 8];
                        mem_wr_q   <= 1'b1;
                        cnt_q      <= cnt_q + 3'd1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign if_grant_out = if_grant_q;
    assign if_done_out  = if_done_q;
    assign if_data_out  = if_data_q;
    assign ls_grant_out = ls_grant_q;
    assign ls_done_out  = ls_done_q;
    assign ls_data_out  = ls_data_q;
    assign mem_a_out    = mem_a_q;
    assign mem_dout     = mem_dout_q;
    assign mem_wr_out   = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam logic [31:0] IoBase = 32'h0003_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rdy, clr, io_full;
    logic        if_req, ls_req, ls_wr;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  if_off, ls_off;
    logic        if_grant, if_done, ls_grant, ls_done, mem_wr;
    logic [31:0] if_data, ls_data, mem_a;
    logic [7:0]  mem_din, mem_dout;

    logic [7:0]  ram [0:262143];
    int          checks = 0;
    int          fails = 0;

    mem_arbiter dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .rdy_in            (rdy),
        .if_req_in         (if_req),
        .if_addr_in        (if_addr),
        .if_offset_in      (if_off),
        .if_grant_out      (if_grant),
        .if_done_out       (if_done),
        .if_data_out       (if_data),
        .ls_req_in         (ls_req),
        .ls_wr_in          (ls_wr),
        .ls_addr_in        (ls_addr),
        .ls_offset_in      (ls_off),
        .ls_data_in        (ls_wdata),
        .ls_grant_out      (ls_grant),
        .ls_done_out       (ls_done),
        .ls_data_out       (ls_data),
        .mem_din           (mem_din),
        .mem_dout          (mem_dout),
        .mem_a_out         (mem_a),
        .mem_wr_out        (mem_wr),
        .io_buffer_full_in (io_full),
        .clear_branch_in   (clr)
    );

    // RAM: byte at the currently driven address is presented before the next rising edge.
    always @(negedge clk) begin
        if (mem_wr) ram[mem_a[17:0]] = mem_dout;
        mem_din = ram[mem_a[17:0]];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
        logic [31:0] w, ai;
        w = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            w = w | (32'(ram[ai[17:0]]) << (8 * i));
        end
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({if_grant, if_done, ls_grant, ls_done, mem_wr} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {if_grant, if_done, ls_grant, ls_done, mem_wr});
        end
        checks++;
        if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            fails++;
            $display("FAIL reset_mem: got a=%h dout=%h want 0/0", mem_a, mem_dout);
        end
        checks++;
        if (if_data !== 32'h0 || ls_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got if=%h ls=%h want 0/0", if_data, ls_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        logic        got;
        logic [31:0] ea;
        ram[18'h01000] = 8'h13;
        ram[18'h01001] = 8'h05;
        ram[18'h01002] = 8'h00;
        ram[18'h01003] = 8'h00;
        if_addr = 32'h1000;
        if_off  = 2'd3;
        if_req  = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            cyc();
            got = if_grant;
        end
        if_req = 1'b0;
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL fetch_grant: got no grant want grant within 8 cycles");
        end
        for (int k = 0; k < 4; k++) begin
            if (k != 0) cyc();
            ea = 32'h1000 + 32'(k);
            checks++;
            if (mem_a !== ea || mem_wr !== 1'b0 || if_done !== 1'b0) begin
                fails++;
                $display("FAIL fetch_addr%0d: got a=%h wr=%b done=%b want a=%h wr=0 done=0",
                         k, mem_a, mem_wr, if_done, ea);
            end
        end
        cyc();
        checks++;
        if (if_done !== 1'b1 || if_data !== 32'h0000_0513) begin
            fails++;
            $display("FAIL fetch_done: got done=%b data=%h want 1/00000513", if_done, if_data);
        end
        cyc();
        checks++;
        if (if_done !== 1'b0 || mem_a !== 32'h1003) begin
            fails++;
            $display("FAIL fetch_idle: got done=%b a=%h want 0/00001003", if_done, mem_a);
        end
    endtask

    task automatic test_arbitration();
        int   seen, last_c;
        logic exp_ls;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        if_addr = 32'h400;
        if_off  = 2'd3;
        ls_addr = 32'h800;
        ls_off  = 2'd3;
        ls_wr   = 1'b0;
        if_req  = 1'b1;
        ls_req  = 1'b1;
        seen = 0;
        last_c = -1;
        exp_ls = 1'b1;
        for (int c = 0; c < 60 && seen < 6; c++) begin
            cyc();
            if (if_grant || ls_grant) begin
                checks++;
                if (ls_grant !== exp_ls || if_grant !== !exp_ls) begin
                    fails++;
                    $display("FAIL arb_order%0d: got if=%b ls=%b want ls=%b",
                             seen, if_grant, ls_grant, exp_ls);
                end
                if (last_c >= 0) begin
                    checks++;
                    if (c - last_c != 5) begin
                        fails++;
                        $display("FAIL arb_gap%0d: got %0d cycles want 5", seen, c - last_c);
                    end
                end
                last_c = c;
                exp_ls = !exp_ls;
                seen++;
            end
        end
        checks++;
        if (seen != 6) begin
            fails++;
            $display("FAIL arb_count: got %0d grants want 6", seen);
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic test_store_load();
        logic        got;
        logic [31:0] d, ea;
        logic [7:0]  eb;
        d = 32'hDEAD_BEEF;
        ls_wr = 1'b1;
        ls_addr = 32'h20;
        ls_off = 2'd3;
        ls_wdata = d;
        ls_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            cyc();
            got = ls_grant;
        end
        ls_req = 1'b0;
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL store_grant: got no grant want grant within 8 cycles");
        end
        for (int k = 0; k < 4; k++) begin
            if (k != 0) cyc();
            ea = 32'h20 + 32'(k);
            eb = 8'(d >> (8 * k));
            checks++;
            if (mem_wr !== 1'b1 || mem_a !== ea || mem_dout !== eb || ls_done !== 1'b0) begin
                fails++;
                $display("FAIL store_byte%0d: got wr=%b a=%h d=%h want 1/%h/%h",
                         k, mem_wr, mem_a, mem_dout, ea, eb);
            end
        end
        cyc();
        checks++;
        if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin
            fails++;
            $display("FAIL store_done: got done=%b wr=%b want 1/0", ls_done, mem_wr);
        end
        cyc();
        ls_wr = 1'b0;
        ls_addr = 32'h22;
        ls_off = 2'd1;
        ls_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            cyc();
            got = ls_grant;
        end
        ls_req = 1'b0;
        cyc();
        checks++;
        if (!got || ls_done !== 1'b0) begin
            fails++;
            $display("FAIL load_early: got grant=%b done=%b want 1/0", got, ls_done);
        end
        cyc();
        checks++;
        if (ls_done !== 1'b1 || ls_data !== 32'h0000_DEAD) begin
            fails++;
            $display("FAIL load_half: got done=%b data=%h want 1/0000dead", ls_done, ls_data);
        end
    endtask

    task automatic test_io_stall();
        io_full = 1'b1;
        ls_wr = 1'b1;
        ls_addr = IoBase;
        ls_off = 2'd0;
        ls_wdata = 32'h41;
        ls_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (ls_grant !== 1'b0 || mem_wr !== 1'b0) begin
                fails++;
                $display("FAIL io_block%0d: got grant=%b wr=%b want 0/0", k, ls_grant, mem_wr);
            end
        end
        io_full = 1'b0;
        cyc();
        ls_req = 1'b0;
        checks++;
        if (ls_grant !== 1'b1 || mem_wr !== 1'b1 || mem_a !== IoBase || mem_dout !== 8'h41) begin
            fails++;
            $display("FAIL io_issue: got g=%b wr=%b a=%h d=%h want 1/1/00030000/41",
                     ls_grant, mem_wr, mem_a, mem_dout);
        end
        cyc();
        checks++;
        if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin
            fails++;
            $display("FAIL io_done: got done=%b wr=%b want 1/0", ls_done, mem_wr);
        end
        cyc();
    endtask

    task automatic test_random_reads();
        logic        use_if, got, ok;
        logic [31:0] a, ea, exp;
        int          n;
        for (int t = 0; t < 16; t++) begin
            use_if = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            a = (t == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 32'h3FFFF));
            n = use_if ? 4 : $urandom_range(1, 4);
            exp = ram_word(a, n);
            if (use_if) begin
                if_addr = a;
                if_off = 2'(n - 1);
                if_req = 1'b1;
            end else begin
                ls_addr = a;
                ls_off = 2'(n - 1);
                ls_wr = 1'b0;
                ls_req = 1'b1;
            end
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                cyc();
                got = if_grant || ls_grant;
            end
            if_req = 1'b0;
            ls_req = 1'b0;
            checks++;
            if (!got || if_grant !== use_if || ls_grant !== !use_if) begin
                fails++;
                $display("FAIL rd_grant%0d: got if=%b ls=%b want if=%b", t, if_grant, ls_grant,
                         use_if);
            end
            ok = 1'b1;
            for (int k = 0; k < n; k++) begin
                if (k != 0) cyc();
                ea = a + 32'(k);
                if (mem_a !== ea || mem_wr !== 1'b0 || if_done || ls_done) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                fails++;
                $display("FAIL rd_seq%0d: got a=%h at end want sequence from %h", t, mem_a, a);
            end
            cyc();
            checks++;
            if (use_if ? (if_done !== 1'b1 || if_data !== exp || ls_done !== 1'b0)
                       : (ls_done !== 1'b1 || ls_data !== exp || if_done !== 1'b0)) begin
                fails++;
                $display("FAIL rd_data%0d: got done=%b%b if=%h ls=%h want %h", t, if_done,
                         ls_done, if_data, ls_data, exp);
            end
            cyc();
        end
    endtask

    task automatic test_random_stores();
        logic [31:0] a, d, ea;
        logic [7:0]  eb;
        logic        f, granted, finished;
        int          n, i;
        for (int t = 0; t < 12; t++) begin
            a = (t < 8) ? IoBase - 32'd3 + 32'($urandom_range(0, 5))
                        : 32'($urandom_range(0, 32'h2FFFF));
            d = $urandom;
            case ($urandom_range(0, 2))
                0:       n = 1;
                1:       n = 2;
                default: n = 4;
            endcase
            ls_wr = 1'b1;
            ls_addr = a;
            ls_off = 2'(n - 1);
            ls_wdata = d;
            ls_req = 1'b1;
            i = 0;
            granted = 1'b0;
            finished = 1'b0;
            for (int c = 0; c < 40 && !finished; c++) begin
                f = 1'($urandom_range(0, 1));
                io_full = f;
                cyc();
                checks++;
                if (!granted) begin
                    if (a >= IoBase && f) begin
                        if (ls_grant !== 1'b0 || mem_wr !== 1'b0) begin
                            fails++;
                            $display("FAIL st_block%0d: got g=%b wr=%b want 0/0", t, ls_grant,
                                     mem_wr);
                        end
                    end else begin
                        if (ls_grant !== 1'b1 || mem_wr !== 1'b1 || mem_a !== a ||
                            mem_dout !== d[7:0]) begin
                            fails++;
                            $display("FAIL st_accept%0d: got g=%b wr=%b a=%h d=%h want 1/1/%h/%h",
                                     t, ls_grant, mem_wr, mem_a, mem_dout, a, d[7:0]);
                        end
                        granted = 1'b1;
                        i = 1;
                        ls_req = 1'b0;
                    end
                end else begin
                    ea = a + 32'(i);
                    eb = 8'(d >> (8 * i));
                    if (i == n) begin
                        if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin
                            fails++;
                            $display("FAIL st_done%0d: got done=%b wr=%b want 1/0", t, ls_done,
                                     mem_wr);
                        end
                        finished = 1'b1;
                    end else if (ea >= IoBase && f) begin
                        if (mem_wr !== 1'b0 || ls_done !== 1'b0) begin
                            fails++;
                            $display("FAIL st_stall%0d: got wr=%b done=%b want 0/0", t, mem_wr,
                                     ls_done);
                        end
                    end else begin
                        if (mem_wr !== 1'b1 || mem_a !== ea || mem_dout !== eb ||
                            ls_done !== 1'b0 || ls_grant !== 1'b0) begin
                            fails++;
                            $display("FAIL st_byte%0d_%0d: got wr=%b a=%h d=%h want 1/%h/%h",
                                     t, i, mem_wr, mem_a, mem_dout, ea, eb);
                        end
                        i++;
                    end
                end
            end
            checks++;
            if (!finished) begin
                fails++;
                $display("FAIL st_timeout%0d: got no done want done within 40 cycles", t);
            end
            io_full = 1'b0;
            ls_req = 1'b0;
            cyc();
        end
    endtask

    task automatic test_flush();
        logic        got, seen_if;
        logic [31:0] exp;
        if_addr = 32'h1100;
        if_off = 2'd3;
        if_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            cyc();
            got = if_grant;
        end
        if_req = 1'b0;
        ls_wr = 1'b0;
        ls_addr = 32'h2000;
        ls_off = 2'd3;
        ls_req = 1'b1;
        exp = ram_word(32'h2000, 4);
        cyc();
        clr = 1'b1;
        cyc();
        checks++;
        if (!got || if_done !== 1'b0 || ls_grant !== 1'b0) begin
            fails++;
            $display("FAIL flush_abort: got g=%b done=%b lsg=%b want 1/0/0", got, if_done,
                     ls_grant);
        end
        clr = 1'b0;
        cyc();
        ls_req = 1'b0;
        checks++;
        if (ls_grant !== 1'b1) begin
            fails++;
            $display("FAIL flush_ls_grant: got %b want 1", ls_grant);
        end
        seen_if = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            clr = (k == 2);
            cyc();
            if (if_done) seen_if = 1'b1;
            if (k < 4 && ls_done) seen_if = 1'b1;
        end
        clr = 1'b0;
        checks++;
        if (ls_done !== 1'b1 || ls_data !== exp || seen_if) begin
            fails++;
            $display("FAIL flush_ls_done: got done=%b data=%h stray=%b want 1/%h/0", ls_done,
                     ls_data, seen_if, exp);
        end
        clr = 1'b1;
        if_addr = 32'h1200;
        if_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++;
            if (if_grant !== 1'b0) begin
                fails++;
                $display("FAIL flush_block%0d: got grant=%b want 0", k, if_grant);
            end
        end
        clr = 1'b0;
        cyc();
        if_req = 1'b0;
        checks++;
        if (if_grant !== 1'b1) begin
            fails++;
            $display("FAIL flush_release: got grant=%b want 1", if_grant);
        end
        repeat (5) cyc();
    endtask

    task automatic test_rdy_freeze();
        logic        got;
        logic [31:0] a, ea, exp;
        a = 32'h3000 + 32'($urandom_range(0, 255));
        exp = ram_word(a, 4);
        if_addr = a;
        if_off = 2'd3;
        if_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            cyc();
            got = if_grant;
        end
        if_req = 1'b0;
        cyc();
        rdy = 1'b0;
        ea = a + 32'd1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (mem_a !== ea || if_done !== 1'b0 || if_grant !== 1'b0) begin
                fails++;
                $display("FAIL rdy_hold%0d: got a=%h done=%b want %h/0", k, mem_a, if_done, ea);
            end
        end
        rdy = 1'b1;
        cyc();
        cyc();
        ea = a + 32'd3;
        checks++;
        if (!got || mem_a !== ea || if_done !== 1'b0) begin
            fails++;
            $display("FAIL rdy_resume: got a=%h done=%b want %h/0", mem_a, if_done, ea);
        end
        cyc();
        checks++;
        if (if_done !== 1'b1 || if_data !== exp) begin
            fails++;
            $display("FAIL rdy_done: got done=%b data=%h want 1/%h", if_done, if_data, exp);
        end
        cyc();
    endtask

    task automatic test_reset_mid_store();
        logic got, stray;
        ls_wr = 1'b1;
        ls_addr = 32'h100;
        ls_off = 2'd3;
        ls_wdata = $urandom;
        ls_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            cyc();
            got = ls_grant;
        end
        ls_req = 1'b0;
        cyc();
        rst_n = 1'b0;
        cyc();
        checks++;
        if (!got || {if_grant, if_done, ls_grant, ls_done, mem_wr} !== 5'b0) begin
            fails++;
            $display("FAIL rst_mid_ctrl: got g=%b ctrl=%b want 1/00000", got,
                     {if_grant, if_done, ls_grant, ls_done, mem_wr});
        end
        checks++;
        if (mem_a !== 32'h0 || mem_dout !== 8'h0 || if_data !== 32'h0 || ls_data !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_data: got a=%h d=%h if=%h ls=%h want all 0", mem_a,
                     mem_dout, if_data, ls_data);
        end
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (6) begin
            cyc();
            if (ls_done || mem_wr) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            fails++;
            $display("FAIL rst_mid_stray: got done/wr activity want none");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test want end within 500us");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'($urandom);
        rst_n = 1'b0;
        rdy = 1'b1;
        clr = 1'b0;
        io_full = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        ls_wr = 1'b0;
        if_addr = '0;
        ls_addr = '0;
        ls_wdata = '0;
        if_off = '0;
        ls_off = '0;
        test_reset();
        test_fetch();
        test_arbitration();
        test_store_load();
        test_io_stall();
        test_random_reads();
        test_random_stores();
        test_flush();
        test_rdy_freeze();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
